// File: rtl/nibble_parity_pkg.sv
// nibble_parity_pkg
// Shared definitions for the nibble parity receiver: the receive FSM state
// type, the data width of one frame and the total number of serial bits in
// a frame (start + data + parity + stop).
package nibble_parity_pkg;

    localparam int DATA_BITS  = 4;
    // start + DATA_BITS data + parity + stop
    localparam int FRAME_BITS = DATA_BITS + 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/parity5_v.sv
// parity5_v
// Five-input XOR of a received nibble and its parity bit. A result of 0
// means the five bits contain an even number of ones.
// Ports:
//   i_data [3:0] - received data nibble
//   i_par        - received parity bit
//   o_xor        - XOR reduction of {i_data, i_par}
module parity5_v (
    input  logic [3:0] i_data,
    input  logic       i_par,
    output logic       o_xor
);

    assign o_xor = ^{i_data, i_par};

endmodule

// File: rtl/nibble_parity_rx_v.sv
// nibble_parity_rx_v
// Serial receiver for a 7-bit frame: start(0), d0..d3 LSB first, parity,
// stop(1). Each bit lasts BIT_TICKS clocks; bits are sampled at mid-bit.
// The received nibble and its error flags are presented one cycle after the
// stop sample through a valid/ready holding register with a sticky overrun
// flag.
// Build option: define NIBBLE_PARITY_ODD_EN to check odd parity instead of
// even parity (only o_par_err changes).
// Ports:
//   i_clk       - clock, all state changes on the rising edge
//   i_rst       - asynchronous active-high reset
//   i_sd        - serial data, idle high, already synchronous to i_clk
//   i_ready     - consumer accepts the held frame when high with o_valid
//   o_data[3:0] - received nibble
//   o_valid     - o_data and flags hold a frame not yet accepted
//   o_par_err   - parity mismatch for the held frame
//   o_frm_err   - stop bit sampled low for the held frame
//   o_ovr       - sticky overrun, cleared only by reset
module nibble_parity_rx_v #(
    parameter int BIT_TICKS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sd,
    input  logic       i_ready,
    output logic [3:0] o_data,
    output logic       o_valid,
    output logic       o_par_err,
    output logic       o_frm_err,
    output logic       o_ovr
);

    import nibble_parity_pkg::*;

    localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_CNT_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0]     HALF_M1  = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(BIT_TICKS - 1);
    // Samples taken before the last data bit: start + d0..d2.
    localparam logic [BIT_CNT_W-1:0] LAST_DAT = BIT_CNT_W'(DATA_BITS);

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   par_q,     par_d;
    logic                   stop_q,    stop_d;
    logic                   load_q,    load_d;
    logic [DATA_BITS-1:0]   data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   ovr_q,     ovr_d;

    logic                   par_xor;
    logic                   par_err_calc;

    parity5_v u_parity5 (
        .i_data (shift_q),
        .i_par  (par_q),
        .o_xor  (par_xor)
    );

`ifdef NIBBLE_PARITY_ODD_EN
    assign par_err_calc = ~par_xor;
`else
    assign par_err_calc = par_xor;
`endif

    // Receive FSM: tick counter runs freely and wraps to 0 on every sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        load_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!i_sd) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // A high line at mid start bit was a glitch.
                    state_d   = i_sd ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = {i_sd, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DAT) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    par_d     = i_sd;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    stop_d  = i_sd;
                    // Frame is delivered even with a low stop bit.
                    load_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output holding register; a load in the accept cycle is not an overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        ovr_d     = ovr_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (load_q) begin
            data_d    = shift_q;
            par_err_d = par_err_calc;
            frm_err_d = ~stop_q;
            valid_d   = 1'b1;
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            load_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            load_q    <= load_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_par_err = par_err_q;
    assign o_frm_err = frm_err_q;
    assign o_ovr     = ovr_q;

endmodule

// File: tb/tb_nibble_parity_rx_v.sv
// tb_nibble_parity_rx_v
// Directed bench for nibble_parity_rx_v with BIT_TICKS=4. Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// Honors NIBBLE_PARITY_ODD_EN for the expected parity flag.
module tb_nibble_parity_rx_v;

    localparam int BT = 4;

`ifdef NIBBLE_PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sd;
    logic       ready;
    logic [3:0] data;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       ovr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_parity_rx_v #(.BIT_TICKS(BT)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sd      (sd),
        .i_ready   (ready),
        .o_data    (data),
        .o_valid   (valid),
        .o_par_err (par_err),
        .o_frm_err (frm_err),
        .o_ovr     (ovr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sd = 1'b1;
        repeat (n) step();
    endtask

    task automatic accept(input string tag);
        ready = 1'b1;
        step();
        check_val(tag, valid, 1'b0);
        ready = 1'b0;
    endtask

    // Drives one full frame; returns 1 ns after the edge where o_valid must
    // rise (t0+27). The edge before that is checked against exp_pre_valid.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                              input logic exp_pre_valid, input logic ready_at_load,
                              input string tag);
        logic [6:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 7 * BT; i++) begin
            sd = bits[i / BT];
            if (i == 7 * BT - 1) ready = ready_at_load;
            step();
            if (i == 7 * BT - 2) check_val({tag, "_pre_valid"}, valid, exp_pre_valid);
        end
        sd    = 1'b1;
        ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        rst   = 1'b1;
        sd    = 1'b1;
        ready = 1'b0;
        repeat (3) step();
        check_val("rst_valid",   valid,   1'b0);
        check_val("rst_data",    data,    4'h0);
        check_val("rst_par_err", par_err, 1'b0);
        check_val("rst_frm_err", frm_err, 1'b0);
        check_val("rst_ovr",     ovr,     1'b0);
        rst = 1'b0;
        idle(3);

        // B, p=1: four ones -> even parity ok
        send_frame(4'hB, 1'b1, 1'b1, 1'b0, 1'b0, "t1");
        check_val("t1_valid",   valid,   1'b1);
        check_val("t1_data",    data,    4'hB);
        check_val("t1_par_err", par_err, ODD);
        check_val("t1_frm_err", frm_err, 1'b0);
        idle(10);
        check_val("t1_hold_valid", valid,   1'b1);
        check_val("t1_hold_data",  data,    4'hB);
        check_val("t1_hold_par",   par_err, ODD);
        accept("t1_accept");

        // B, p=0: three ones -> even parity error
        send_frame(4'hB, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
        check_val("t2_data",    data,    4'hB);
        check_val("t2_par_err", par_err, 1'b1 ^ ODD);
        check_val("t2_frm_err", frm_err, 1'b0);
        accept("t2_accept");

        // 5, p=0, stop=0: framing error, parity fine (two ones)
        send_frame(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, "t3");
        check_val("t3_valid",   valid,   1'b1);
        check_val("t3_data",    data,    4'h5);
        check_val("t3_frm_err", frm_err, 1'b1);
        check_val("t3_par_err", par_err, ODD);
        idle(6);
        accept("t3_accept");
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, "t3b");
        check_val("t3b_data",    data,    4'h3);
        check_val("t3b_frm_err", frm_err, 1'b0);
        check_val("t3b_par_err", par_err, ODD);
        accept("t3b_accept");

        // Two-cycle low glitch is a false start
        sd = 1'b0;
        step();
        step();
        sd   = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (valid) seen = 1'b1;
        end
        check_val("t4_no_valid", seen, 1'b0);
        send_frame(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, "t4");
        check_val("t4_data",    data,    4'h9);
        check_val("t4_par_err", par_err, ODD);
        accept("t4_accept");

        // Back-to-back frames, nobody accepting: overrun
        send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, "t5a");
        send_frame(4'h6, 1'b0, 1'b1, 1'b1, 1'b0, "t5b");
        check_val("t5_valid", valid, 1'b1);
        check_val("t5_data",  data,  4'h6);
        check_val("t5_ovr",   ovr,   1'b1);
        accept("t5_accept");
        check_val("t5_ovr_sticky", ovr, 1'b1);
        rst = 1'b1;
        #1;
        check_val("t5_ovr_rst", ovr, 1'b0);
        step();
        rst = 1'b0;
        idle(2);

        // Back-to-back with acceptance in the second load cycle: no overrun
        send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, "t6a");
        check_val("t6a_data", data, 4'hA);
        check_val("t6a_ovr",  ovr,  1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 1'b1, 1'b1, "t6b");
        check_val("t6b_valid", valid, 1'b1);
        check_val("t6b_data",  data,  4'h6);
        check_val("t6b_ovr",   ovr,   1'b0);

        // Reset in the middle of frame F while frame 6 is still held
        for (int i = 0; i < 2 * BT + 2; i++) begin
            sd = (i < BT) ? 1'b0 : 1'b1;
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("t7_rst_valid", valid,   1'b0);
        check_val("t7_rst_data",  data,    4'h0);
        check_val("t7_rst_par",   par_err, 1'b0);
        check_val("t7_rst_frm",   frm_err, 1'b0);
        check_val("t7_rst_ovr",   ovr,     1'b0);
        step();
        check_val("t7_rst_hold_valid", valid, 1'b0);
        rst  = 1'b0;
        sd   = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (valid) seen = 1'b1;
        end
        check_val("t7_discard", seen, 1'b0);
        send_frame(4'h2, 1'b1 ^ ODD, 1'b1, 1'b0, 1'b0, "t7");
        check_val("t7_valid",   valid,   1'b1);
        check_val("t7_data",    data,    4'h2);
        check_val("t7_par_err", par_err, 1'b0);
        check_val("t7_frm_err", frm_err, 1'b0);
        check_val("t7_ovr",     ovr,     1'b0);
        accept("t7_accept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
